// File: rtl/tx_medida_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_medida_serial
// Purpose  : Sends each latched 3-digit BCD measurement as ASCII over 8N1 UART,
//            terminated by '#'; define TX_CRLF_EN to append CR LF.
// Revision : 1.0 - initial release
// ============================================================================
module tx_medida_serial #(
    parameter int BAUD_DIV = 434,
    parameter int DIV_W    = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] medida,
    input  logic        pronto,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        fim,
    output logic [3:0]  db_estado
);

`ifdef TX_CRLF_EN
    localparam logic [2:0] c_last_char = 3'd5;
`else
    localparam logic [2:0] c_last_char = 3'd3;
`endif
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BAUD_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_pre  = DIV_W'(BAUD_DIV - 2);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        TRANSMITE = 4'd2,
        PROXIMO   = 4'd3,
        FINAL     = 4'd4
    } state_t;

    state_t           r_estado;
    logic [11:0]      r_dado;
    logic [2:0]       r_char_idx;
    logic [3:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_baud_cnt;
    logic             r_tx;
    logic             r_ocupado;
    logic             r_fim;
    logic [7:0]       w_char;
    logic             w_bit;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    always_comb begin
        w_char = 8'h23;
        case (r_char_idx)
            3'd0:    w_char = ascii_digit(r_dado[11:8]);
            3'd1:    w_char = ascii_digit(r_dado[7:4]);
            3'd2:    w_char = ascii_digit(r_dado[3:0]);
`ifdef TX_CRLF_EN
            3'd4:    w_char = 8'h0D;
            3'd5:    w_char = 8'h0A;
`endif
            default: w_char = 8'h23;
        endcase
    end

    // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
    always_comb begin
        w_bit = 1'b1;
        if (r_bit_cnt == 4'd0)
            w_bit = 1'b0;
        else if (r_bit_cnt <= 4'd8)
            w_bit = w_char[3'(r_bit_cnt - 4'd1)];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_dado     <= 12'd0;
            r_char_idx <= 3'd0;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_ocupado  <= 1'b0;
            r_fim      <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    r_estado <= ESPERA;
                end
                ESPERA: begin
                    r_tx      <= 1'b1;
                    r_ocupado <= 1'b0;
                    if (pronto) begin
                        r_dado     <= medida;
                        r_char_idx <= 3'd0;
                        r_bit_cnt  <= 4'd0;
                        r_baud_cnt <= '0;
                        r_estado   <= TRANSMITE;
                    end
                end
                TRANSMITE: begin
                    r_tx      <= w_bit;
                    r_ocupado <= 1'b1;
                    if (r_baud_cnt == c_div_last) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                    // Leave one clock early so PROXIMO fills the stop bit's last cycle.
                    if (r_bit_cnt == 4'd9 && r_baud_cnt == c_div_pre)
                        r_estado <= PROXIMO;
                end
                PROXIMO: begin
                    r_tx       <= 1'b1;
                    r_ocupado  <= 1'b1;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 4'd0;
                    if (r_char_idx == c_last_char) begin
                        r_estado <= FINAL;
                    end else begin
                        r_char_idx <= r_char_idx + 3'd1;
                        r_estado   <= TRANSMITE;
                    end
                end
                FINAL: begin
                    r_tx      <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_fim     <= 1'b1;
                    r_estado  <= ESPERA;
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign saida_serial = r_tx;
    assign ocupado      = r_ocupado;
    assign fim          = r_fim;
    assign db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_tx_medida_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_medida_serial
// Purpose  : Randomized scoreboard bench; a UART receiver decodes the line and
//            compares characters and fim timing with a message-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_medida_serial;

    localparam int BD = 31;
    localparam int DW = 5;
`ifdef TX_CRLF_EN
    localparam int NCH = 6;
`else
    localparam int NCH = 4;
`endif
    localparam int MSG_CYC = NCH * 10 * BD;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        pronto = 1'b0;
    logic [11:0] medida = 12'd0;
    logic        saida_serial;
    logic        ocupado;
    logic        fim;
    logic [3:0]  db_estado;

    tx_medida_serial #(.BAUD_DIV(BD), .DIV_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .medida       (medida),
        .pronto       (pronto),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .fim          (fim),
        .db_estado    (db_estado)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Message-level reference model.
    logic [7:0] exp_q[$];
    int         fim_q[$];
    int         busy_until = 0;
    int         last_start = -100;
    int         last_fim   = -100;

    function automatic logic [7:0] exp_char(input logic [11:0] m, input int i);
        logic [3:0] nib;
        if (i < 3) begin
            nib = m[11 - 4*i -: 4];
            return (nib > 4'd9) ? 8'h3F : 8'h30 + {4'h0, nib};
        end
        case (i)
            3:       return 8'h23;
            4:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    function automatic bit model_ocupado(input int c);
        return (c >= last_start + 1) && (c < last_fim);
    endfunction

    task automatic accept(input logic [11:0] m, input int e);
        for (int i = 0; i < NCH; i++) exp_q.push_back(exp_char(m, i));
        last_start = e;
        last_fim   = e + 1 + MSG_CYC;
        fim_q.push_back(last_fim);
        busy_until = last_fim + 1;
    endtask

    // Hold pronto for n edges; every edge reaching the idle state starts a message.
    task automatic drive_pronto(input logic [11:0] m, input int n, output bit acc_first);
        int e;
        acc_first = 1'b0;
        @(negedge clock);
        medida = m;
        pronto = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = cyc + 1;
            if (e >= busy_until) begin
                accept(m, e);
                if (i == 0) acc_first = 1'b1;
            end
            @(negedge clock);
        end
        pronto = 1'b0;
    endtask

    task automatic send(input logic [11:0] m);
        bit acc;
        drive_pronto(m, 1, acc);
        @(negedge clock);
        chk("ocupado_after_pronto", int'(ocupado), int'(model_ocupado(cyc)));
        if (acc) chk("start_bit_latency", int'(saida_serial), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || fim_q.size() != 0) && n < 4 * MSG_CYC) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", exp_q.size() + fim_q.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    // Independent UART receiver and fim monitor.
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    int         rx_k    = 0;
    logic [7:0] rx_sh   = 8'd0;
    logic [7:0] rx_exp;
    int         fim_exp;

    always @(negedge clock) begin
        if (reset) begin
            rx_busy = 1'b0;
        end else begin
            if (fim) begin
                if (fim_q.size() == 0) chk("fim_unexpected", 1, 0);
                else begin
                    fim_exp = fim_q.pop_front();
                    chk("fim_cycle", cyc, fim_exp);
                    chk("ocupado_at_fim", int'(ocupado), 0);
                end
            end
            if (!rx_busy) begin
                if (!saida_serial) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_busy && (rx_cnt % BD) == BD / 2) begin
                rx_k = rx_cnt / BD;
                if (rx_k == 0) chk("rx_start_bit", int'(saida_serial), 0);
                else if (rx_k <= 8) rx_sh[rx_k-1] = saida_serial;
                else begin
                    chk("rx_stop_bit", int'(saida_serial), 1);
                    if (exp_q.size() == 0) chk("char_unexpected", int'(rx_sh), -1);
                    else begin
                        rx_exp = exp_q.pop_front();
                        chk("rx_char", int'(rx_sh), int'(rx_exp));
                    end
                    rx_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] m;
        bit          acc;

        // Reset held for 2 us.
        repeat (50) @(negedge clock);
        chk("rst_saida", int'(saida_serial), 1);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_fim", int'(fim), 0);
        chk("rst_estado", int'(db_estado), 0);
        repeat (50) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("estado_after_rst", int'(db_estado), 1);
        repeat (3) @(negedge clock);

        send(12'h075);
        wait_idle();
        send(12'h1A9);
        wait_idle();
        send(12'h294);
        wait_idle();

        // Busy: stale medida and second pronto must not disturb the frame.
        send(12'h456);
        repeat (5 * BD) @(negedge clock);
        medida = 12'h999;
        send(12'h123);
        wait_idle();

        // Reset during the tens character's start bit.
        send(12'h888);
        repeat (10 * BD + 1) @(negedge clock);
        chk("tens_start_low", int'(saida_serial), 0);
        #2;
        reset = 1'b1;
        exp_q.delete();
        fim_q.delete();
        busy_until = 0;
        last_start = -100;
        last_fim   = -100;
        #1;
        chk("midrst_saida", int'(saida_serial), 1);
        chk("midrst_ocupado", int'(ocupado), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        send(12'h000);
        wait_idle();

        // pronto held through fim: back-to-back message one cycle after fim.
        m = 12'($urandom);
        drive_pronto(m, MSG_CYC + 4, acc);
        chk("held_first_accept", int'(acc), 1);
        wait_idle();

        for (int k = 0; k < 10; k++) begin
            m = 12'($urandom);
            send(m);
            repeat ($urandom_range(0, MSG_CYC + 10)) @(negedge clock);
        end
        wait_idle();

        chk("final_ocupado", int'(ocupado), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_medida_serial.md
Name: tx_medida_serial

Overview:
- Downstream consumer of interface_hcsr04.
- On each `pronto` pulse, latches the 3-digit BCD `medida` (hundreds, tens, units) and sends it over an 8N1 UART line as four ASCII characters: hundreds, tens, units, then '#' (0x23).
- Feeds the PC/serial monitor link of the sonar system.
- Built from a frame FSM, a baud-tick counter, a bit counter and a character index.

Parameters:
- BAUD_DIV, 434, clocks per serial bit (50 MHz / 115200 baud).
- DIV_W, 9, width of the baud counter; must satisfy 2^DIV_W > BAUD_DIV.

Ports:
- clock  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  asynchronous, active-high.
- medida  input  12  BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- pronto  input  1  measurement valid; single-cycle pulse from interface_hcsr04.
- saida_serial  output  1  UART TX line; idle high.
- ocupado  output  1  high while a message is being sent.
- fim  output  1  one-cycle pulse when the message completes.
- db_estado  output  4  current FSM state code (debug).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high; all state updates on the rising edge of clock.
- Reset values: saida_serial=1, ocupado=0, fim=0, db_estado=0, all counters 0, latched data 0.
- States and codes:
  - INICIAL (0): always moves to ESPERA on the next edge.
  - ESPERA (1): idle; saida_serial=1. When pronto=1 is sampled, latches medida, clears char index and bit counter, and goes to TRANSMITE.
  - TRANSMITE (2): shifts the frame of the current character.
  - PROXIMO (3): one-cycle internal step that advances the char index; not visible on the line.
  - FINAL (4): pulses fim, then returns to ESPERA.
  - State 0xF is never used.
- Frame format:
  - Per character: start bit (0), 8 data bits LSB first, stop bit (1). 10 bits, each exactly BAUD_DIV clocks.
  - The next start bit immediately follows the previous stop bit; the PROXIMO cycle is absorbed into the last stop-bit count, so there is no idle gap.
- Latency:
  - Edge E samples pronto=1 in ESPERA. saida_serial goes 0 at edge E+1.
  - ocupado goes 1 at edge E+1.
  - fim=1 for exactly one cycle starting at edge E+1+40*BAUD_DIV. ocupado=0 from that same edge.
- Character encoding:
  - Each digit d (0..9) is sent as 0x30+d.
  - Any BCD nibble > 9 is sent as '?' (0x3F).
  - Terminator is always 0x23.
- pronto handling:
  - pronto is ignored in every state except ESPERA; no queuing.
  - medida changes after the latch edge do not affect the message in flight.
  - pronto held high continuously: a new message starts from ESPERA one cycle after fim.
- Reset mid-message: the line returns to 1 asynchronously, the message is abandoned, and no fim pulse is produced.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps.
  - The bit counter advances on wrap; the character ends after bit 9 wraps.

Optional Feature:
- Macro: TX_CRLF_EN.
- When defined: after '#', two more characters are sent, CR (0x0D) then LF (0x0A). The message is 6 characters; fim asserts at E+1+60*BAUD_DIV.
- When undefined: the message is 4 characters and no CR/LF is sent.
- Port list is identical in both builds.

Test Plan:
- Reset check: assert reset for 2 us -> saida_serial=1, ocupado=0, fim=0, db_estado=0. After release, db_estado=1 within 2 cycles.
- Normal message: medida=12'h075, pronto pulse of 1 cycle -> line decodes to 0x30, 0x37, 0x35, 0x23 at 115200 baud. fim pulses once exactly 17360 cycles after the start-bit edge (TX_CRLF_EN undefined).
- Invalid BCD: medida=12'h1A9 -> characters 0x31, 0x3F, 0x39, 0x23.
- Busy and stale data: second pronto with medida=12'h123 while ocupado=1; medida changed to 12'h999 mid-message -> the first message is unchanged and the second pronto is ignored. Exactly one fim is produced.
- Reset mid-message: assert reset during the tens character -> saida_serial=1 immediately, no fim. A following pronto with 12'h000 sends "000#" correctly.
- Optional feature: build with TX_CRLF_EN and send medida=12'h294 -> line decodes to 0x32, 0x39, 0x34, 0x23, 0x0D, 0x0A. fim asserts 26040 cycles after the start-bit edge.
